// File: rtl/clk_pkg.sv
// Shared types and constants for the clk_* monitoring blocks.
// Holds the monitor state encoding and the all-ones saturation limit.
package clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    // Widest counter supported; users slice the low CNT_W bits.
    localparam int                   CNT_W_MAX    = 64;
    localparam logic [CNT_W_MAX-1:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Signal bundle between a divided-clock source/consumer and clk_div_monitor.
// master drives the divided clock and stall threshold; slave is the monitor.
interface clk_div_monitor_if #(
    parameter int CNT_W = 32
);
    logic             clk_div_in;
    logic [CNT_W-1:0] timeout;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             stalled;

    modport master (
        output clk_div_in, timeout,
        input  rise_pulse, fall_pulse, period, high_time, period_valid, stalled
    );

    modport slave (
        input  clk_div_in, timeout,
        output rise_pulse, fall_pulse, period, high_time, period_valid, stalled
    );
endinterface

// File: rtl/sync_ff.sv
// N-stage synchroniser for a single asynchronous bit, async active-low clear.
// Latency N clk_in edges from d to q; no backpressure.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk_in,
    input  logic arst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] r_s;

    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            r_s <= '0;
        end else begin
            r_s <= {r_s[N-2:0], d};
        end
    end

    assign q = r_s[N-1];
endmodule

// File: rtl/clk_div_monitor.sv
// Synchronises a divided clock, emits rise/fall strobes (SYNC_STAGES+1 edges after
// sampling), measures period/high time and flags a stalled divider; no backpressure.
module clk_div_monitor
    import clk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             arst_n,
    clk_div_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] L_MAX = CNT_ALL_ONES[CNT_W-1:0];

    logic             w_sync;
    logic             w_rise;
    logic             w_fall;
    logic             w_stall_hit;
    logic             w_measuring;
    logic [CNT_W-1:0] w_rise_inc;
    logic [CNT_W-1:0] w_idle_inc;

    logic             r_prev;
    logic             r_rise_pulse;
    logic             r_fall_pulse;
    logic             r_period_valid;
    logic             r_stalled;
    logic [CNT_W-1:0] r_rise_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    state_t           r_state;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .arst_n (arst_n),
        .d      (bus.clk_div_in),
        .q      (w_sync)
    );

    assign w_rise      = w_sync & ~r_prev;
    assign w_fall      = ~w_sync & r_prev;
    assign w_rise_inc  = (r_rise_cnt == L_MAX) ? L_MAX : r_rise_cnt + CNT_W'(1);
    assign w_idle_inc  = (r_idle_cnt == L_MAX) ? L_MAX : r_idle_cnt + CNT_W'(1);
    assign w_measuring = (r_state == ST_ARMED) || (r_state == ST_LOCKED);
    // Compare against timeout-1 so stalled asserts exactly timeout cycles after the last edge.
    assign w_stall_hit = (bus.timeout != '0) && (r_idle_cnt >= bus.timeout - CNT_W'(1));

    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            r_prev       <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
            r_rise_cnt   <= '0;
            r_idle_cnt   <= '0;
        end else begin
            r_prev       <= w_sync;
            r_rise_pulse <= w_rise;
            r_fall_pulse <= w_fall;
            r_rise_cnt   <= w_rise ? '0 : w_rise_inc;
            r_idle_cnt   <= (w_rise || w_fall) ? '0 : w_idle_inc;
        end
    end

    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            r_state        <= ST_IDLE;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_period       <= '0;
            r_high_time    <= '0;
        end else begin
            if (w_rise) begin
                // Leaving STALL re-arms without trusting the interval that spanned the stall.
                r_state        <= w_measuring ? ST_LOCKED : ST_ARMED;
                r_period_valid <= w_measuring;
                r_stalled      <= 1'b0;
                if (w_measuring) begin
                    r_period <= w_rise_inc;
                end
            end else if (!w_fall && (r_state != ST_STALL) && w_stall_hit) begin
                r_state        <= ST_STALL;
                r_period_valid <= 1'b0;
                r_stalled      <= 1'b1;
            end
            if (w_fall && (r_state != ST_IDLE)) begin
                r_high_time <= w_rise_inc;
            end
        end
    end

    assign bus.rise_pulse   = r_rise_pulse;
    assign bus.fall_pulse   = r_fall_pulse;
    assign bus.period       = r_period;
    assign bus.high_time    = r_high_time;
    assign bus.period_valid = r_period_valid;
    assign bus.stalled      = r_stalled;
endmodule
